// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared instruction-memory types and byte geometry
package instr_mem_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/instr_loader.sv
// instr_loader: streams 32-bit words into byte-wide little-endian instruction memory
// Define INSTR_LOADER_CHECKSUM_EN to enable the additive word checksum.
module instr_loader
  import instr_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [ADDRESS_WIDTH-2:0] word_count_i,
  input  logic                     word_valid_i,
  input  logic [DATA_WIDTH-1:0]    word_i,
  output logic                     word_ready_o,
  output logic                     we_o,
  output logic [ADDRESS_WIDTH-1:0] waddr_o,
  output logic [BYTE_WIDTH-1:0]    wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DATA_WIDTH-1:0]    checksum_o
);
  loader_state_t state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [ADDRESS_WIDTH-2:0] words_left;
  logic [1:0] byte_idx;
  logic [DATA_WIDTH-1:0] word_reg;
  logic last_byte;
  assign last_byte = byte_idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    word_ready_o = 1'b0;
    we_o = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    busy_o = state != IDLE;
    done_o = 1'b0;
    case (state)
      IDLE: state_nxt = start_i ? (word_count_i == '0 ? DONE : ACCEPT) : IDLE;
      ACCEPT: begin
        word_ready_o = 1'b1;
        state_nxt = word_valid_i ? WRITE : ACCEPT;
      end
      WRITE: begin
        we_o = 1'b1;
        waddr_o = ptr + ADDRESS_WIDTH'(byte_idx);
        wdata_o = word_reg[BYTE_WIDTH*byte_idx +: BYTE_WIDTH];
        state_nxt = !last_byte ? WRITE : (words_left == (ADDRESS_WIDTH-1)'(1) ? DONE : ACCEPT);
      end
      DONE: begin
        done_o = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end
  // ptr always stays word-aligned; byte_idx supplies the low address bits
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ptr <= '0;
      words_left <= '0;
      byte_idx <= '0;
      word_reg <= '0;
    end else begin
      case (state)
        IDLE:
          if (start_i) begin
            ptr <= base_addr_i & ~ADDRESS_WIDTH'(BYTES_PER_WORD - 1);
            words_left <= word_count_i;
          end
        ACCEPT:
          if (word_valid_i) begin
            word_reg <= word_i;
            byte_idx <= '0;
          end
        WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (last_byte) begin
            ptr <= ptr + ADDRESS_WIDTH'(BYTES_PER_WORD);
            words_left <= words_left - (ADDRESS_WIDTH-1)'(1);
          end
        end
        DONE: ;
      endcase
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) checksum <= '0;
    else if (state == IDLE && start_i) checksum <= '0;
    else if (state == ACCEPT && word_valid_i) checksum <= checksum + word_i;
  assign checksum_o = checksum;
`else
  assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized + directed bench for instr_loader against a queue-based model
module tb_instr_loader;
  localparam int A = 8;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, word_valid_i = 1'b0;
  logic [A-1:0] base_addr_i = '0;
  logic [A-2:0] word_count_i = '0;
  logic [31:0] word_i = '0;
  logic word_ready_o, we_o, busy_o, done_o;
  logic [A-1:0] waddr_o;
  logic [7:0] wdata_o;
  logic [31:0] checksum_o;
  int errors = 0, checks = 0;

  instr_loader #(.ADDRESS_WIDTH(A), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_count_i(word_count_i), .word_valid_i(word_valid_i), .word_i(word_i),
    .word_ready_o(word_ready_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: expected byte writes as a queue of {addr,data}, plus load-level flags
  bit m_busy = 0, m_accept = 0, m_done = 0;
  int m_left = 0;
  logic [7:0] m_ptr = '0;
  logic [31:0] m_sum = '0;
  logic [15:0] mq[$];
  logic [15:0] wlog[$];
  int done_cnt = 0;

  initial begin : model
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_busy = 0; m_accept = 0; m_done = 0; m_sum = '0; mq.delete();
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (start_i) begin
          m_busy = 1; m_ptr = base_addr_i & 8'hFC; m_left = int'(word_count_i); m_sum = '0;
          if (m_left == 0) m_done = 1; else m_accept = 1;
        end
      end else if (m_accept) begin
        if (word_valid_i) begin
          for (int b = 0; b < 4; b++) mq.push_back({m_ptr + 8'(b), word_i[8*b +: 8]});
          m_ptr = m_ptr + 8'd4; m_sum = m_sum + word_i; m_accept = 0;
        end
      end else begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_left--;
          if (m_left == 0) m_done = 1; else m_accept = 1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk_i);
      chk("we", we_o, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("waddr", waddr_o, mq[0][15:8]);
        chk("wdata", wdata_o, mq[0][7:0]);
      end
      chk("ready", word_ready_o, m_accept);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk("checksum", checksum_o, m_sum);
`else
      chk("checksum", checksum_o, 32'h0);
`endif
      if (we_o) wlog.push_back({waddr_o, wdata_o});
      if (done_o) done_cnt++;
    end
  end

  task automatic start_load(input logic [7:0] base, input int cnt);
    base_addr_i = base; word_count_i = 7'(cnt); start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    @(negedge clk_i);
    while (!word_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!word_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1 at %0t", $time);
    end
    repeat (gap) @(negedge clk_i);
    word_valid_i = 1'b1; word_i = w;
    @(posedge clk_i); #1 word_valid_i = 1'b0; word_i = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk_i);
    while (!done_o && n < 400) begin @(negedge clk_i); n++; end
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL done_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_ready"}, word_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_waddr"}, waddr_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_cksum"}, checksum_o, 0);
  endtask

  logic [15:0] exp1[4] = '{16'h10EF, 16'h11BE, 16'h12AD, 16'h13DE};
  logic [15:0] expw[8] = '{16'hFC44, 16'hFD33, 16'hFE22, 16'hFF11,
                          16'h0088, 16'h0177, 16'h0266, 16'h0355};

  initial begin
    #1 reset_outputs_zero("rst");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    #1 chk("idle_writes", wlog.size(), 0);

    // single word
    wlog.delete(); done_cnt = 0;
    start_load(8'h10, 1);
    send_word(32'hDEADBEEF, 0);
    wait_done();
    chk("single_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("single_byte", wlog[i], exp1[i]);
    chk("single_done", done_cnt, 1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("single_cksum", checksum_o, 32'hDEADBEEF);
`else
    chk("single_cksum", checksum_o, 32'h0);
`endif

    // three words with valid gaps, plus an ignored start mid-load
    wlog.delete(); done_cnt = 0;
    start_load(8'h00, 3);
    send_word(32'h03020100, 2);
    start_i = 1'b1; base_addr_i = 8'h80; word_count_i = 7'd9;
    @(posedge clk_i); #1 start_i = 1'b0;
    send_word(32'h07060504, 2);
    send_word(32'h0B0A0908, 2);
    wait_done();
    chk("b2b_count", wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++) chk("b2b_byte", wlog[i], {8'(i), 8'(i)});
    chk("b2b_done", done_cnt, 1);

    // misaligned base with wrap
    wlog.delete(); done_cnt = 0;
    start_load(8'hFE, 2);
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 1);
    wait_done();
    chk("wrap_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("wrap_byte", wlog[i], expw[i]);

    // zero-length load
    wlog.delete(); done_cnt = 0;
    start_load(8'h20, 0);
    wait_done();
    chk("zero_writes", wlog.size(), 0);
    chk("zero_done", done_cnt, 1);

    // reset during byte_idx 2
    start_load(8'h40, 2);
    send_word(32'hA5A5_5A5A, 0);
    @(posedge clk_i); @(posedge clk_i); #2;
    chk("mid_we", we_o, 1);
    chk("mid_addr", waddr_o, 8'h42);
    rst_ni = 1'b0;
    #1 reset_outputs_zero("mid_rst");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wlog.delete(); done_cnt = 0;
    start_load(8'h40, 1);
    send_word(32'hCAFEF00D, 0);
    wait_done();
    chk("after_rst_count", wlog.size(), 4);
    if (wlog.size() > 0) chk("after_rst_first", wlog[0], 16'h400D);

    // randomized loads, last one overruns the memory size
    for (int t = 0; t < 8; t++) begin
      int cnt;
      cnt = (t == 7) ? 65 : $urandom_range(0, 5);
      start_load(8'($urandom), cnt);
      for (int k = 0; k < cnt; k++) begin
        send_word($urandom, $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          start_i = 1'b1; base_addr_i = 8'($urandom); word_count_i = 7'($urandom);
          @(posedge clk_i); #1 start_i = 1'b0;
        end
      end
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader writing the instruction memory: the writer-side counterpart of the byte-addressed, little-endian instruction ROM read port. It accepts 32-bit instruction words over a valid/ready stream, serialises each into four byte writes (least-significant byte at the lowest address) and drives a byte-wide memory write port. `busy_o` holds the core off while loading.

## Interface
- `ADDRESS_WIDTH`, default 8: byte address width; memory holds 2**ADDRESS_WIDTH bytes.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 32 (4 bytes).
- `clk_i`  in  1: clock; all state on rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `start_i`  in  1: begin a load; sampled only in IDLE.
- `base_addr_i`  in  ADDRESS_WIDTH: first byte address; bits [1:0] ignored (forced 0).
- `word_count_i`  in  ADDRESS_WIDTH-1: number of words to load, 0..2**(ADDRESS_WIDTH-2).
- `word_valid_i`  in  1: stream word present.
- `word_i`  in  DATA_WIDTH: stream instruction word.
- `word_ready_o`  out  1: loader can take a word.
- `we_o`  out  1: byte write enable.
- `waddr_o`  out  ADDRESS_WIDTH: byte write address.
- `wdata_o`  out  8: byte write data.
- `busy_o`  out  1: load in progress (any state but IDLE).
- `done_o`  out  1: one-cycle pulse at load completion.
- `checksum_o`  out  DATA_WIDTH: additive checksum (see Configuration).

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: `start_i`=1 latches ptr=`{base_addr_i[A-1:2],2'b00}`, words_left=`word_count_i`, clears checksum; -> ACCEPT, or -> DONE if `word_count_i`=0 (no writes).
- ACCEPT: `word_ready_o`=1. On `word_valid_i`&&`word_ready_o` at an edge: word_reg<=`word_i`, byte_idx<=0, checksum+=`word_i`; -> WRITE. No valid: stay.
- WRITE: `we_o`=1, `waddr_o`=ptr+byte_idx (mod 2**A), `wdata_o`=word_reg[8*byte_idx+:8]. byte_idx increments each cycle; after byte_idx=3: ptr+=4 (mod 2**A), words_left-=1; -> DONE if words_left was 1, else -> ACCEPT.
- DONE: `done_o`=1 for exactly one cycle; -> IDLE.
- `start_i` outside IDLE ignored. `word_valid_i` outside ACCEPT ignored (not consumed).
- Address wrap: ptr past 2**A-4 wraps to 0; writes continue, no error.
- `word_count_i` > 2**(A-2) is a caller error; behaviour: loads exactly that many words, wrapping and overwriting.

## Timing
- Reset (async assert): state IDLE; `we_o`, `word_ready_o`, `busy_o`, `done_o` =0; `waddr_o`, `wdata_o`, `checksum_o` =0, immediately, without clock.
- Reset mid-load: write stream aborts same instant; partial memory contents left as is.
- All outputs are functions of registered state only (no combinational path input->output).
- Handshake edge N -> bytes written at edges N+1..N+4 -> `word_ready_o` high again cycle after N+4. Throughput 1 word / 5 cycles.
- Last byte write edge M -> `done_o` high during cycle M..M+1, `busy_o` falls after DONE.
- Zero-length load: `start_i` edge -> DONE one cycle -> IDLE; `we_o` never asserted.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined: 32-bit wrapping sum of all accepted words, cleared on start, valid from `done_o` until next start.
- Undefined: no accumulator logic; `checksum_o` tied to 0.

## Structure
- Shared package `instr_mem_pkg`: state enum type `loader_state_t`, `BYTES_PER_WORD`=4, `BYTE_WIDTH`=8.
- Single module; no sub-module needed (byte serialiser is the WRITE state plus a 2-bit counter).

## Test plan
- Reset: hold `rst_ni`=0 -> all outputs 0, `busy_o`=0; release, idle 10 cycles -> no writes.
- Single word: base 0x10, count 1, word 0xDEADBEEF -> writes 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE on 4 consecutive cycles; `done_o` one pulse; checksum 0xDEADBEEF when enabled.
- Back-to-back with valid gaps: count 3, valid deasserted 2 cycles between words -> exactly 12 writes, addresses 0x00..0x0B, ready low throughout each WRITE burst.
- Wrap and misalign: base 0xFE (forced 0xFC), count 2, words 0x11223344, 0x55667788 -> bytes to 0xFC..0xFF then 0x00..0x03.
- Zero count and ignored start: count 0 -> `done_o` pulse, no `we_o`; `start_i` pulsed during load -> no effect on ptr or count.
- Reset mid-load: assert `rst_ni`=0 during byte_idx 2 -> `we_o` drops asynchronously, state IDLE, next load starts cleanly.
